fpu_normalize_sequencer: RTL and testbench

Multi-cycle normalization controller for the FPU add/sub result path. It accepts an unnormalized exponent/mantissa/carry triple from the adder stage, then normalizes it one bit per cycle. A carry causes one right shift; otherwise leading zeros are removed by left shifts until the hidden bit is set or the exponent floor is reached. Results are handed to the pack stage through a valid/ready handshake, with overflow, underflow and zero flags.

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/fpu_normalize_sequencer_norm_step.sv | 73 +++++++
 rtl/fpu_normalize_sequencer.sv | 157 +++++++++++++++
 tb/tb_fpu_normalize_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU normalization path.
// Holds the default field widths, the all-ones exponent constant used for
// Inf/NaN and overflow detection, and the sequencer state encoding.
package fpu_pkg;

  localparam int EXPONENT_LENGTH = 8;
  localparam int MANTISSA_LENGTH = 23;

  localparam logic [EXPONENT_LENGTH-1:0] EXP_ALL_ONES = '1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NORM = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    NORM = ST_NORM,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/fpu_normalize_sequencer_norm_step.sv
// norm_step: one combinational normalization step.
// Given the current {carry, exponent, mantissa, count} it produces the values
// for the next cycle, a done flag and the result flags. Rules are applied in
// priority order: Inf/NaN pass-through, carry right shift, zero, already
// normalized, exponent floor (denormal), otherwise one left shift.
// Ports:
//   carry, exponent, mantissa, count             current working values
//   next_exponent, next_mantissa, next_count     values after this step
//   done                                         normalization finished
//   overflow, underflow, zero                    result flags (valid with done)
module norm_step #(
  parameter int EXPONENT_LENGTH = fpu_pkg::EXPONENT_LENGTH,
  parameter int MANTISSA_LENGTH = fpu_pkg::MANTISSA_LENGTH
) (
  input  logic                       carry,
  input  logic [EXPONENT_LENGTH-1:0] exponent,
  input  logic [MANTISSA_LENGTH:0]   mantissa,
  input  logic [EXPONENT_LENGTH-1:0] count,
  output logic [EXPONENT_LENGTH-1:0] next_exponent,
  output logic [MANTISSA_LENGTH:0]   next_mantissa,
  output logic [EXPONENT_LENGTH-1:0] next_count,
  output logic                       done,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       zero
);

  localparam logic [EXPONENT_LENGTH-1:0] EXP_ONE = {{(EXPONENT_LENGTH-1){1'b0}}, 1'b1};
  localparam logic [EXPONENT_LENGTH-1:0] EXP_MAX = '1;

  logic [EXPONENT_LENGTH-1:0] exponent_inc;

  assign exponent_inc = exponent + EXP_ONE;

  always_comb begin
    next_exponent = exponent;
    next_mantissa = mantissa;
    next_count    = count;
    done          = 1'b0;
    overflow      = 1'b0;
    underflow     = 1'b0;
    zero          = 1'b0;

    if (exponent == EXP_MAX && !carry) begin
      done = 1'b1;
    end else if (carry) begin
      // The carry bit becomes the new hidden bit; the old LSB is dropped.
      next_mantissa = {1'b1, mantissa[MANTISSA_LENGTH:1]};
      next_exponent = exponent_inc;
      if (exponent_inc == EXP_MAX) begin
        next_mantissa = {1'b1, {MANTISSA_LENGTH{1'b0}}};
        overflow      = 1'b1;
      end
      done = 1'b1;
    end else if (mantissa == '0) begin
      next_exponent = '0;
      zero          = 1'b1;
      done          = 1'b1;
    end else if (mantissa[MANTISSA_LENGTH]) begin
      done = 1'b1;
    end else if (exponent <= EXP_ONE) begin
      // Cannot shift further without going below the floor: leave as denormal.
      next_exponent = '0;
      underflow     = 1'b1;
      done          = 1'b1;
    end else begin
      next_mantissa = {mantissa[MANTISSA_LENGTH-1:0], 1'b0};
      next_exponent = exponent - EXP_ONE;
      next_count    = count + EXP_ONE;
    end
  end

endmodule

// File: rtl/fpu_normalize_sequencer.sv
// fpu_normalize_sequencer: multi-cycle normalizer for the add/sub result.
// Accepts an unnormalized {carry, exponent, mantissa} triple, normalizes one
// bit per cycle using norm_step, and presents the registered result to the
// pack stage with a valid/ready handshake.
// Ports:
//   clk, rst                      clock, async active-high reset
//   in_valid / in_ready           input handshake (ready only when idle)
//   in_carry, in_exponent, in_mantissa   unnormalized input triple
//   out_valid / out_ready         output handshake
//   out_exponent, out_mantissa    normalized exponent and fraction
//   out_shift_count               number of left shifts applied
//   out_overflow, out_underflow, out_zero   result flags
//   busy                          an operation is in flight
module fpu_normalize_sequencer #(
  parameter int EXPONENT_LENGTH = fpu_pkg::EXPONENT_LENGTH,
  parameter int MANTISSA_LENGTH = fpu_pkg::MANTISSA_LENGTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_carry,
  input  logic [EXPONENT_LENGTH-1:0] in_exponent,
  input  logic [MANTISSA_LENGTH:0]   in_mantissa,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXPONENT_LENGTH-1:0] out_exponent,
  output logic [MANTISSA_LENGTH-1:0] out_mantissa,
  output logic [EXPONENT_LENGTH-1:0] out_shift_count,
  output logic                       out_overflow,
  output logic                       out_underflow,
  output logic                       out_zero,
  output logic                       busy
);

  import fpu_pkg::*;

  state_t state, state_next;

  logic                       carry_q;
  logic [EXPONENT_LENGTH-1:0] exponent_q;
  logic [MANTISSA_LENGTH:0]   mantissa_q;
  logic [EXPONENT_LENGTH-1:0] count_q;
  logic                       overflow_q;
  logic                       underflow_q;
  logic                       zero_q;

  logic [EXPONENT_LENGTH-1:0] step_exponent;
  logic [MANTISSA_LENGTH:0]   step_mantissa;
  logic [EXPONENT_LENGTH-1:0] step_count;
  logic                       step_done;
  logic                       step_overflow;
  logic                       step_underflow;
  logic                       step_zero;

  norm_step #(
    .EXPONENT_LENGTH(EXPONENT_LENGTH),
    .MANTISSA_LENGTH(MANTISSA_LENGTH)
  ) u_norm_step (
    .carry         (carry_q),
    .exponent      (exponent_q),
    .mantissa      (mantissa_q),
    .count         (count_q),
    .next_exponent (step_exponent),
    .next_mantissa (step_mantissa),
    .next_count    (step_count),
    .done          (step_done),
    .overflow      (step_overflow),
    .underflow     (step_underflow),
    .zero          (step_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DONE is left only after the registered result has actually been handed off.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)               state_next = NORM;
      NORM:    if (step_done)              state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  // Working registers and output registers. The first DONE cycle copies the
  // working values into the output registers; out_valid rises after that copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q         <= 1'b0;
      exponent_q      <= '0;
      mantissa_q      <= '0;
      count_q         <= '0;
      overflow_q      <= 1'b0;
      underflow_q     <= 1'b0;
      zero_q          <= 1'b0;
      out_valid       <= 1'b0;
      out_exponent    <= '0;
      out_mantissa    <= '0;
      out_shift_count <= '0;
      out_overflow    <= 1'b0;
      out_underflow   <= 1'b0;
      out_zero        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry_q     <= in_carry;
            exponent_q  <= in_exponent;
            mantissa_q  <= in_mantissa;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            zero_q      <= 1'b0;
          end
        end
        NORM: begin
          exponent_q <= step_exponent;
          mantissa_q <= step_mantissa;
          count_q    <= step_count;
          if (step_done) begin
            carry_q     <= 1'b0;
            overflow_q  <= step_overflow;
            underflow_q <= step_underflow;
            zero_q      <= step_zero;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid       <= 1'b1;
            out_exponent    <= exponent_q;
            out_mantissa    <= mantissa_q[MANTISSA_LENGTH-1:0];
            out_shift_count <= count_q;
            out_overflow    <= overflow_q;
            out_underflow   <= underflow_q;
            out_zero        <= zero_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_fpu_normalize_sequencer.sv
// Testbench for fpu_normalize_sequencer: directed cases plus randomized
// triples, checked through a scoreboard queue against a value-level model.
module tb_fpu_normalize_sequencer;

  typedef struct {
    logic [7:0]  e;
    logic [22:0] f;
    logic [7:0]  cnt;
    logic        ovf;
    logic        unf;
    logic        zro;
    int          lat;
    int          acc;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_carry = 1'b0;
  logic [7:0]  in_exponent = '0;
  logic [23:0] in_mantissa = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_exponent;
  logic [22:0] out_mantissa;
  logic [7:0]  out_shift_count;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_zero;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int readyMode = 1;
  expect_t sb[$];

  fpu_normalize_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_carry        (in_carry),
    .in_exponent     (in_exponent),
    .in_mantissa     (in_mantissa),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_exponent    (out_exponent),
    .out_mantissa    (out_mantissa),
    .out_shift_count (out_shift_count),
    .out_overflow    (out_overflow),
    .out_underflow   (out_underflow),
    .out_zero        (out_zero),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Model: normalize by counting leading zeros and limiting the shift by
  // how far the exponent can drop before reaching the floor of 1.
  function automatic expect_t refModel(bit c, int e, int m);
    expect_t r;
    int msb, lz, room, k, nm;
    r.ovf = 0; r.unf = 0; r.zro = 0; k = 0;
    if (e == 255 && !c) begin
      r.e = 8'(e); r.f = 23'(m);
    end else if (c) begin
      nm = (m >> 1) + (1 << 23);
      r.e = 8'((e + 1) % 256);
      if (r.e == 8'hFF) begin nm = 1 << 23; r.ovf = 1; end
      r.f = 23'(nm);
    end else if (m == 0) begin
      r.e = 0; r.f = 0; r.zro = 1;
    end else begin
      msb = 0;
      for (int i = 0; i < 24; i++) if (((m >> i) & 1) == 1) msb = i;
      lz = 23 - msb;
      room = (e > 1) ? e - 1 : 0;
      k = (lz < room) ? lz : room;
      nm = m << k;
      if (k == lz) r.e = 8'(e - k);
      else begin r.e = 0; r.unf = 1; end
      r.f = 23'(nm);
    end
    r.cnt = 8'(k);
    r.lat = k + 2;
    r.acc = 0;
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic checkOutput(expect_t x);
    check("result {exp,frac,cnt,ovf,unf,zero}",
          {out_exponent, out_mantissa, out_shift_count, out_overflow, out_underflow, out_zero},
          {x.e, x.f, x.cnt, x.ovf, x.unf, x.zro});
  endtask

  task automatic applyStimulus(bit c, logic [7:0] e, logic [23:0] m);
    expect_t x;
    int waited = 0;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    if (!in_ready) begin
      check("in_ready wait timeout", 0, 1);
      return;
    end
    in_carry = c; in_exponent = e; in_mantissa = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = refModel(c, int'(e), int'(m));
    x.acc = cycle;
    sb.push_back(x);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (sb.size() != 0 || busy) check("drain timeout", 0, 1);
  endtask

  // Downstream ready: random, always high, or held low.
  initial begin
    forever begin
      @(posedge clk); #2;
      case (readyMode)
        0:       out_ready = ($urandom_range(0, 2) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency on out_valid rise, result on handshake, stability while stalled.
  initial begin
    logic prevValid = 1'b0;
    logic prevStall = 1'b0;
    logic [56:0] snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevValid = 1'b0; prevStall = 1'b0;
      end else begin
        if (out_valid && prevStall)
          check("stall stability",
                {out_exponent, out_mantissa, out_shift_count, out_overflow, out_underflow, out_zero}, snap);
        if (out_valid && !prevValid) begin
          if (sb.size() == 0) check("unexpected out_valid", 1, 0);
          else check("latency", cycle - sb[0].acc, sb[0].lat);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) check("unexpected handshake", 1, 0);
          else checkOutput(sb.pop_front());
        end
        prevValid = out_valid;
        prevStall = out_valid && !out_ready;
        snap = {out_exponent, out_mantissa, out_shift_count, out_overflow, out_underflow, out_zero};
      end
    end
  end

  initial begin
    bit c;
    int r;
    logic [7:0] e;
    logic [23:0] m;

    #3;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset outputs", {out_exponent, out_mantissa, out_shift_count, out_overflow, out_underflow, out_zero}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    readyMode = 1;
    applyStimulus(0, 8'h80, 24'h800000); waitDrain();
    applyStimulus(0, 8'h90, 24'h000100); waitDrain();
    applyStimulus(1, 8'h7F, 24'hC00001); waitDrain();
    applyStimulus(1, 8'hFE, 24'h123456); waitDrain();
    applyStimulus(0, 8'h03, 24'h000001); waitDrain();
    applyStimulus(0, 8'h00, 24'h012345); waitDrain();
    applyStimulus(0, 8'hFF, 24'h400001); waitDrain();

    // Stall with zero result.
    readyMode = 2;
    applyStimulus(0, 8'h55, 24'h000000);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("stall out_valid seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall in_ready low", in_ready, 0);
    end
    readyMode = 1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready before handoff edge", in_ready, 0);
    @(negedge clk);
    check("in_ready after handoff", in_ready, 1);
    check("out_valid after handoff", out_valid, 0);
    waitDrain();

    // Abort during the fifth shift.
    applyStimulus(0, 8'h90, 24'h000100);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    void'(sb.pop_back());
    check("abort in_ready", in_ready, 1);
    check("abort out_valid", out_valid, 0);
    check("abort busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(0, 8'h90, 24'h000100); waitDrain();

    // Randomized triples with random backpressure.
    readyMode = 0;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      c = (r < 2);
      e = 8'($urandom_range(0, 254));
      m = 24'($urandom() >> $urandom_range(8, 31));
      if (r == 2) e = 8'hFF;
      if (r == 3) m = 24'h0;
      if (r == 4) e = 8'($urandom_range(0, 4));
      applyStimulus(c, e, m);
    end
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
